// File: rtl/plic_resolver_pkg.sv
`default_nettype none
// ============================================================================
// Module   : plic_resolver_pkg
// Desc     : Shared PLIC sizing constants and types for the priority resolver.
// Revision : 1.0 - initial release
// ============================================================================
package plic_resolver_pkg;

    localparam int PLIC_SOURCE_COUNT    = 15;
    localparam int PLIC_TARGET_COUNT    = 2;
    localparam int PLIC_SOURCE_WIDTH    = $clog2(PLIC_SOURCE_COUNT + 1);
    localparam int PLIC_PRIORITY_WIDTH  = 3;

    // Number of cycles outputs are hidden after a claim strobe.
    localparam int PLIC_BLACKOUT_CYCLES = 2;

    // Candidate carried through the compare tree.
    typedef struct packed {
        logic [PLIC_PRIORITY_WIDTH-1:0] prio;
        logic [PLIC_SOURCE_WIDTH-1:0]   id;
    } type_prio_id_s;

endpackage : plic_resolver_pkg
`default_nettype wire

// File: rtl/plic_max_tree.sv
`default_nettype none
// ============================================================================
// Module   : plic_max_tree
// Desc     : Combinational balanced max-reduction over per-source priorities.
//            Returns the highest priority and its ID; lowest ID wins a tie.
// Revision : 1.0 - initial release
// ============================================================================
module plic_max_tree
    import plic_resolver_pkg::*;
#(
    parameter int SRC_COUNT = PLIC_SOURCE_COUNT,
    parameter int SRC_W     = $clog2(SRC_COUNT + 1),
    parameter int PRIO_W    = PLIC_PRIORITY_WIDTH
) (
    input  logic [SRC_COUNT*PRIO_W-1:0] i_prio,
    output logic [PRIO_W-1:0]           o_best_prio,
    output logic [SRC_W-1:0]            o_best_id
);

    // Leaves padded to a power of two; padding carries priority 0 and sits to
    // the right of every real source, so it can never displace a real winner.
    localparam int LEAVES = (SRC_COUNT > 1) ? (2 ** $clog2(SRC_COUNT)) : 1;
    localparam int NODES  = 2 * LEAVES - 1;

    typedef struct packed {
        logic [PRIO_W-1:0] prio;
        logic [SRC_W-1:0]  id;
    } node_t;

    // Heap-ordered tree: node n has children 2n+1 (lower IDs) and 2n+2.
    node_t w_node [NODES];

    // Build leaves then reduce bottom-up; the right child wins only on a
    // strictly greater priority, which gives lowest-ID-wins on ties.
    always_comb begin
        for (int n = 0; n < NODES; n++) begin
            w_node[n] = '0;
        end
        for (int i = 0; i < SRC_COUNT; i++) begin
            w_node[LEAVES-1+i].prio = i_prio[i*PRIO_W +: PRIO_W];
            w_node[LEAVES-1+i].id   = SRC_W'(i + 1);
        end
        for (int n = LEAVES - 2; n >= 0; n--) begin
            w_node[n] = (w_node[2*n+2].prio > w_node[2*n+1].prio) ?
                        w_node[2*n+2] : w_node[2*n+1];
        end
    end

    assign o_best_prio = w_node[0].prio;
    assign o_best_id   = w_node[0].id;

endmodule : plic_max_tree
`default_nettype wire

// File: rtl/plic_resolver.sv
`default_nettype none
// ============================================================================
// Module   : plic_resolver
// Desc     : Per-target PLIC priority resolution. Two registered stages
//            (masking, then max/threshold) plus a post-claim blackout that
//            hides results which may still reflect a just-claimed source.
// Revision : 1.0 - initial release
// ============================================================================
module plic_resolver
    import plic_resolver_pkg::*;
#(
    parameter int SRC_COUNT = PLIC_SOURCE_COUNT,
    parameter int TGT_COUNT = PLIC_TARGET_COUNT,
    parameter int SRC_W     = $clog2(SRC_COUNT + 1),
    parameter int PRIO_W    = PLIC_PRIORITY_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [SRC_COUNT-1:0]           irq_pending_i,
    input  logic [SRC_COUNT*PRIO_W-1:0]    src_priority_i,
    input  logic [TGT_COUNT*SRC_COUNT-1:0] irq_enable_i,
    input  logic [TGT_COUNT*PRIO_W-1:0]    threshold_i,
    input  logic [TGT_COUNT-1:0]           claim_req_i,
    output logic [TGT_COUNT*SRC_W-1:0]     claim_idx_o,
    output logic [TGT_COUNT-1:0]           irq_o
);

    localparam logic [1:0] BLACKOUT_LOAD = 2'(PLIC_BLACKOUT_CYCLES);

    logic [TGT_COUNT-1:0][SRC_COUNT*PRIO_W-1:0] w_eff;
    logic [TGT_COUNT-1:0][SRC_COUNT*PRIO_W-1:0] r_eff;
    logic [TGT_COUNT-1:0][PRIO_W-1:0]           r_thr;
    logic [TGT_COUNT-1:0][PRIO_W-1:0]           w_best_prio;
    logic [TGT_COUNT-1:0][SRC_W-1:0]            w_best_id;
    logic [TGT_COUNT-1:0]                       w_valid;
    logic [TGT_COUNT-1:0][SRC_W-1:0]            r_win_id;
    logic [TGT_COUNT-1:0]                       r_win_irq;
    logic [1:0]                                 r_blackout;
    logic                                       w_blackout;

    // Effective priority: a source only competes if pending and enabled.
    always_comb begin
        w_eff = '0;
        for (int t = 0; t < TGT_COUNT; t++) begin
            for (int i = 0; i < SRC_COUNT; i++) begin
                if (irq_pending_i[i] && irq_enable_i[t*SRC_COUNT+i]) begin
                    w_eff[t][i*PRIO_W +: PRIO_W] = src_priority_i[i*PRIO_W +: PRIO_W];
                end
            end
        end
    end

    // Stage 1: capture masked priorities and thresholds together so they stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_eff <= '0;
            r_thr <= '0;
        end else begin
            r_eff <= w_eff;
            r_thr <= threshold_i;
        end
    end

    generate
        for (genvar t = 0; t < TGT_COUNT; t++) begin : g_tgt
            plic_max_tree #(
                .SRC_COUNT (SRC_COUNT),
                .SRC_W     (SRC_W),
                .PRIO_W    (PRIO_W)
            ) u_max_tree (
                .i_prio      (r_eff[t]),
                .o_best_prio (w_best_prio[t]),
                .o_best_id   (w_best_id[t])
            );

            // Strictly above threshold; priority 0 never interrupts.
            assign w_valid[t] = (w_best_prio[t] > r_thr[t]) && (w_best_prio[t] != '0);
        end
    endgenerate

    // Stage 2: register the per-target winner, forcing ID 0 when not valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_id  <= '0;
            r_win_irq <= '0;
        end else begin
            for (int t = 0; t < TGT_COUNT; t++) begin
                r_win_id[t] <= w_valid[t] ? w_best_id[t] : '0;
            end
            r_win_irq <= w_valid;
        end
    end

    // Blackout counter: any claim (re)loads it; otherwise count down to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blackout <= '0;
        end else if (|claim_req_i) begin
            r_blackout <= BLACKOUT_LOAD;
        end else if (r_blackout != 2'd0) begin
            r_blackout <= r_blackout - 2'd1;
        end
    end

    assign w_blackout  = (r_blackout != 2'd0);
    assign claim_idx_o = w_blackout ? '0 : r_win_id;
    assign irq_o       = w_blackout ? '0 : r_win_irq;

endmodule : plic_resolver
`default_nettype wire
